emmc_cmd_dev: RTL and testbench
===============================

EMMC_CMD_DEV -- requirements
Module: emmc_cmd_dev

Interface
REQ-001 Parameter OCR, 32 bits, default 32'h00FF8080; OCR value returned in R3; bit 31 is replaced by the busy/ready flag.
REQ-002 Parameter CID, 120 bits, default 120'h70_0100_4D4D43_30_0000_0001_0000; CID[127:8] returned in R2 for CMD2.
REQ-003 Parameter CSD, 120 bits, default all zero; CSD[127:8] returned in R2 for CMD9.
REQ-004 Parameter NCR, integer, default 2, range 2..64; clocks from command end bit to response start bit.
REQ-005 Parameter INIT_CMD1_CNT, integer, default 2; number of CMD1s answered busy before ready.
REQ-006 clk_i  in  1  sole clock; CMD line sampled and driven on rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 emmc_cmd_i  in  1  host-driven CMD line, idle high.
REQ-009 emmc_cmd_o  out  1  device CMD bit, registered.
REQ-010 emmc_cmd_oe_o  out  1  device CMD output enable, registered.
REQ-011 cmd_valid_o  out  1  one-cycle pulse per accepted command.
REQ-012 cmd_idx_o  out  6  index of the last accepted command, held until the next one.
REQ-013 cmd_arg_o  out  32  argument of the last accepted command, held.
REQ-014 crc_err_o  out  1  one-cycle pulse on a rejected frame (CRC or framing).
REQ-015 card_state_o  out  4  current card state: 0 idle, 1 ready, 2 ident, 3 stby, 4 tran.
REQ-016 rca_o  out  16  relative card address, latched by CMD3.

Function
REQ-017 Receiver: armed when oe=0; emmc_cmd_i=0 starts a frame; captures 48 bits MSB-first: start, transmission, idx[5:0], arg[31:0], crc[6:0], end.
REQ-018 CRC7: poly x^7+x^3+1, init 0, computed over the first 40 frame bits.
REQ-019 Reject on CRC mismatch, transmission bit 0, or end bit 0: pulse crc_err_o, no response, no state change, set sticky COM_CRC_ERROR.
REQ-020 Accepted frame: cmd_valid_o, cmd_idx_o and cmd_arg_o update in the cycle after the end bit is sampled.
REQ-021 Command table: CMD0 any state -> idle, rca_o and CMD1 count cleared, no response.
REQ-022 CMD1 in idle -> R3; bit31=0 for the first INIT_CMD1_CNT CMD1s (stay idle), afterwards bit31=1 -> ready.
REQ-023 CMD2 in ready -> R2 (CID) -> ident; CMD3 in ident -> R1, rca_o<=arg[31:16] -> stby.
REQ-024 CMD9 in stby with arg[31:16]==rca_o -> R2 (CSD), state unchanged.
REQ-025 CMD7 in stby with matching RCA -> R1 -> tran; CMD7 in tran with non-matching RCA -> stby, no response.
REQ-026 CMD6, CMD8, CMD17, CMD24 in tran -> R1, state unchanged.
REQ-027 Any other index/state combination: no response, set sticky ILLEGAL_COMMAND; cmd_valid_o still pulses.
REQ-028 R1 (48 bits): 0, 0, idx[5:0], status[31:0], CRC7, 1.
REQ-029 R1 status: [23] COM_CRC_ERROR, [22] ILLEGAL_COMMAND, [12:9] state at command receipt, [8]=1, others 0.
REQ-030 Sticky status bits are reported in the next R1 and then cleared.
REQ-031 R2 (136 bits): 0, 0, 6'b111111, reg[127:8], CRC7 over reg[127:8], 1.
REQ-032 R3 (48 bits): 0, 0, 6'b111111, OCR with bit 31 substituted, 7'b1111111, 1.
REQ-033 Timing: end bit sampled at edge T; oe=1 with the start bit from edge T+NCR; oe stays high for exactly 48 or 136 cycles.
REQ-034 emmc_cmd_o=1 whenever oe=0.
REQ-035 CMD-line activity is ignored from the end bit until the cycle after oe falls.
REQ-036 A new start bit is accepted from the second cycle after oe falls.
REQ-037 State is updated when the response starts; for no-response commands it updates in the cycle after acceptance.
REQ-038 States: RX_IDLE, RX_SHIFT, NCR_WAIT, TX_SHIFT; TX length counter is 8 bits.

Reset
REQ-039 rst_i=1 at any point, including mid-frame or mid-response, gives on the next edge: oe=0, cmd_o=1, cmd_valid_o=0, crc_err_o=0.
REQ-040 Reset also clears: cmd_idx_o=0, cmd_arg_o=0, card_state_o=0, rca_o=0, sticky bits and CMD1 count; receiver returns to RX_IDLE.

Verification
REQ-041 CMD0 (arg 0, CRC 7'h4A) -> no oe for 200 cycles, card_state_o=0, cmd_valid_o pulse with idx 0.
REQ-042 Three CMD1 with arg 0x40FF8080, defaults -> R3 OCR fields 0x00FF8080, 0x00FF8080, 0x80FF8080; card_state_o=1 after the third; start bit at T+2.
REQ-043 CMD2, then CMD3 with arg 0x00040000 -> R2 with correct CID and CRC7 (136 cycles of oe); R1 idx 3, status 0x00000500; rca_o=0x0004, state 3.
REQ-044 CMD7 with arg 0x00040000 and a flipped CRC bit -> crc_err_o pulse, no oe within 64 cycles, state 3; repeat with good CRC -> R1 status 0x00800700, state 4.
REQ-045 In tran: CMD2 -> no response, then CMD17 -> R1 status 0x00400900; rst_i asserted 20 cycles into an R2 -> oe=0 and cmd_o=1 next edge, all outputs at reset values.

Source files
------------

// File: rtl/emmc_cmd_dev_if.sv
// eMMC CMD-line bundle: host-driven CMD input, device CMD driver and decoded-command reporting.
interface emmc_cmd_dev_if;
  logic        emmc_cmd_i;
  logic        emmc_cmd_o;
  logic        emmc_cmd_oe_o;
  logic        cmd_valid_o;
  logic [5:0]  cmd_idx_o;
  logic [31:0] cmd_arg_o;
  logic        crc_err_o;
  logic [3:0]  card_state_o;
  logic [15:0] rca_o;

  modport slave (
    input  emmc_cmd_i,
    output emmc_cmd_o, emmc_cmd_oe_o, cmd_valid_o, cmd_idx_o, cmd_arg_o,
    output crc_err_o, card_state_o, rca_o
  );

  modport master (
    output emmc_cmd_i,
    input  emmc_cmd_o, emmc_cmd_oe_o, cmd_valid_o, cmd_idx_o, cmd_arg_o,
    input  crc_err_o, card_state_o, rca_o
  );
endinterface

// File: rtl/emmc_cmd_dev.sv
// eMMC device-side CMD line: receives 48-bit host commands, runs the identification/transfer
// state machine and answers with R1/R2/R3 responses after NCR clocks.
module emmc_cmd_dev #(
  parameter logic [31:0]  OCR           = 32'h00FF8080,
  parameter logic [119:0] CID           = 120'h70_0100_4D4D43_30_0000_0001_0000,
  parameter logic [119:0] CSD           = '0,
  parameter int unsigned  NCR           = 2,
  parameter int unsigned  INIT_CMD1_CNT = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  emmc_cmd_dev_if.slave bus
);

  typedef enum logic [1:0] {RxIdle, RxShift, NcrWait, TxShift} st_e;
  typedef enum logic [2:0] {RspNone, RspR1, RspR2Cid, RspR2Csd, RspR3} rsp_e;

  localparam logic [3:0] CsIdle  = 4'd0;
  localparam logic [3:0] CsReady = 4'd1;
  localparam logic [3:0] CsIdent = 4'd2;
  localparam logic [3:0] CsStby  = 4'd3;
  localparam logic [3:0] CsTran  = 4'd4;

  // Leading zeros leave a zero-initialised CRC7 untouched, so shorter messages are zero-extended.
  function automatic logic [6:0] crc7(input logic [119:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  localparam logic [6:0] CidCrc = crc7(CID);
  localparam logic [6:0] CsdCrc = crc7(CSD);

  st_e          st_q, st_d;
  logic [46:0]  rx_sr_q, rx_sr_d;
  logic [5:0]   rx_cnt_q, rx_cnt_d;
  logic [6:0]   ncr_cnt_q, ncr_cnt_d;
  logic [7:0]   tx_cnt_q, tx_cnt_d;
  logic [135:0] resp_q, resp_d;
  logic         cmd_o_q, cmd_o_d, oe_q, oe_d, valid_q, valid_d, crc_err_q, crc_err_d;
  logic         hold_q, hold_d, stk_crc_q, stk_crc_d, stk_ill_q, stk_ill_d;
  logic [5:0]   idx_q, idx_d;
  logic [31:0]  arg_q, arg_d;
  logic [3:0]   state_q, state_d, pend_q, pend_d;
  logic [15:0]  rca_q, rca_d;
  logic [7:0]   cmd1_q, cmd1_d;

  logic [47:0]  frame;
  logic [5:0]   idx;
  logic [31:0]  arg, status;
  logic [39:0]  r1_body;
  logic         frame_ok, rca_match, busy, legal;
  logic [3:0]   new_state;
  rsp_e         rsp_kind;

  always_comb begin
    st_d      = st_q;
    rx_sr_d   = rx_sr_q;
    rx_cnt_d  = rx_cnt_q;
    ncr_cnt_d = ncr_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    resp_d    = resp_q;
    cmd_o_d   = cmd_o_q;
    oe_d      = oe_q;
    valid_d   = 1'b0;
    crc_err_d = 1'b0;
    hold_d    = 1'b0;
    stk_crc_d = stk_crc_q;
    stk_ill_d = stk_ill_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    state_d   = state_q;
    pend_d    = pend_q;
    rca_d     = rca_q;
    cmd1_d    = cmd1_q;

    frame     = {rx_sr_q, bus.emmc_cmd_i};
    idx       = frame[45:40];
    arg       = frame[39:8];
    frame_ok  = !frame[47] && frame[46] && frame[0] && (crc7({80'b0, frame[47:8]}) == frame[7:1]);
    rca_match = (arg[31:16] == rca_q);
    busy      = ({24'b0, cmd1_q} < INIT_CMD1_CNT);
    status    = {8'b0, stk_crc_q, stk_ill_q, 9'b0, state_q, 1'b1, 8'b0};
    r1_body   = {2'b00, idx, status};
    rsp_kind  = RspNone;
    new_state = state_q;
    legal     = 1'b0;

    unique case (st_q)
      RxIdle: begin
        // Hold masks the first cycle after the response so the line release is not a start bit.
        if (!hold_q && !bus.emmc_cmd_i) begin
          rx_sr_d  = '0;
          rx_cnt_d = 6'd1;
          st_d     = RxShift;
        end
      end
      RxShift: begin
        if (rx_cnt_q == 6'd47) begin
          st_d = RxIdle;
          if (!frame_ok) begin
            crc_err_d = 1'b1;
            stk_crc_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            idx_d   = idx;
            arg_d   = arg;
            case (idx)
              6'd0: begin
                legal   = 1'b1;
                state_d = CsIdle;
                rca_d   = '0;
                cmd1_d  = '0;
              end
              6'd1: if (state_q == CsIdle) begin
                legal    = 1'b1;
                rsp_kind = RspR3;
                if (busy) cmd1_d = cmd1_q + 8'd1;
                else      new_state = CsReady;
              end
              6'd2: if (state_q == CsReady) begin
                legal     = 1'b1;
                rsp_kind  = RspR2Cid;
                new_state = CsIdent;
              end
              6'd3: if (state_q == CsIdent) begin
                legal     = 1'b1;
                rsp_kind  = RspR1;
                rca_d     = arg[31:16];
                new_state = CsStby;
              end
              6'd9: if (state_q == CsStby && rca_match) begin
                legal    = 1'b1;
                rsp_kind = RspR2Csd;
              end
              6'd7: begin
                if (state_q == CsStby && rca_match) begin
                  legal     = 1'b1;
                  rsp_kind  = RspR1;
                  new_state = CsTran;
                end else if (state_q == CsTran && !rca_match) begin
                  legal   = 1'b1;
                  state_d = CsStby;
                end
              end
              6'd6, 6'd8, 6'd17, 6'd24: if (state_q == CsTran) begin
                legal    = 1'b1;
                rsp_kind = RspR1;
              end
              default: ;
            endcase
            if (!legal) stk_ill_d = 1'b1;
            if (rsp_kind != RspNone) begin
              st_d      = NcrWait;
              ncr_cnt_d = 7'(NCR - 1);
              pend_d    = new_state;
              tx_cnt_d  = 8'd47;
            end
            case (rsp_kind)
              RspR1: begin
                resp_d    = {r1_body, crc7({80'b0, r1_body}), 1'b1, 88'b0};
                stk_crc_d = 1'b0;
                stk_ill_d = 1'b0;
              end
              RspR2Cid: begin
                resp_d   = {2'b00, 6'h3F, CID, CidCrc, 1'b1};
                tx_cnt_d = 8'd135;
              end
              RspR2Csd: begin
                resp_d   = {2'b00, 6'h3F, CSD, CsdCrc, 1'b1};
                tx_cnt_d = 8'd135;
              end
              RspR3:   resp_d = {2'b00, 6'h3F, !busy, OCR[30:0], 8'hFF, 88'b0};
              default: ;
            endcase
          end
        end else begin
          rx_sr_d  = {rx_sr_q[45:0], bus.emmc_cmd_i};
          rx_cnt_d = rx_cnt_q + 6'd1;
        end
      end
      NcrWait: begin
        if (ncr_cnt_q == 7'd0) begin
          oe_d    = 1'b1;
          cmd_o_d = resp_q[135];
          resp_d  = {resp_q[134:0], 1'b0};
          state_d = pend_q;
          st_d    = TxShift;
        end else begin
          ncr_cnt_d = ncr_cnt_q - 7'd1;
        end
      end
      TxShift: begin
        if (tx_cnt_q == 8'd0) begin
          oe_d    = 1'b0;
          cmd_o_d = 1'b1;
          hold_d  = 1'b1;
          st_d    = RxIdle;
        end else begin
          cmd_o_d  = resp_q[135];
          resp_d   = {resp_q[134:0], 1'b0};
          tx_cnt_d = tx_cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q      <= RxIdle;
      rx_sr_q   <= '0;
      rx_cnt_q  <= '0;
      ncr_cnt_q <= '0;
      tx_cnt_q  <= '0;
      resp_q    <= '0;
      cmd_o_q   <= 1'b1;
      oe_q      <= 1'b0;
      valid_q   <= 1'b0;
      crc_err_q <= 1'b0;
      hold_q    <= 1'b0;
      stk_crc_q <= 1'b0;
      stk_ill_q <= 1'b0;
      idx_q     <= '0;
      arg_q     <= '0;
      state_q   <= CsIdle;
      pend_q    <= CsIdle;
      rca_q     <= '0;
      cmd1_q    <= '0;
    end else begin
      st_q      <= st_d;
      rx_sr_q   <= rx_sr_d;
      rx_cnt_q  <= rx_cnt_d;
      ncr_cnt_q <= ncr_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      resp_q    <= resp_d;
      cmd_o_q   <= cmd_o_d;
      oe_q      <= oe_d;
      valid_q   <= valid_d;
      crc_err_q <= crc_err_d;
      hold_q    <= hold_d;
      stk_crc_q <= stk_crc_d;
      stk_ill_q <= stk_ill_d;
      idx_q     <= idx_d;
      arg_q     <= arg_d;
      state_q   <= state_d;
      pend_q    <= pend_d;
      rca_q     <= rca_d;
      cmd1_q    <= cmd1_d;
    end
  end

  assign bus.emmc_cmd_o    = cmd_o_q;
  assign bus.emmc_cmd_oe_o = oe_q;
  assign bus.cmd_valid_o   = valid_q;
  assign bus.cmd_idx_o     = idx_q;
  assign bus.cmd_arg_o     = arg_q;
  assign bus.crc_err_o     = crc_err_q;
  assign bus.card_state_o  = state_q;
  assign bus.rca_o         = rca_q;

endmodule

// File: tb/tb_emmc_cmd_dev.sv
// Randomised bench for emmc_cmd_dev: a host-side frame driver plus a card-level reference model
// predicting acceptance, response bits, latency and card state for every command.
module tb_emmc_cmd_dev;
  localparam int unsigned  NCR  = 2;
  localparam int unsigned  INIT = 2;
  localparam logic [31:0]  OCR  = 32'h00FF8080;
  localparam logic [119:0] CID  = 120'h70_0100_4D4D43_30_0000_0001_0000;
  localparam logic [119:0] CSD  = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  emmc_cmd_dev_if bus ();

  emmc_cmd_dev #(
    .OCR(OCR), .CID(CID), .CSD(CSD), .NCR(NCR), .INIT_CMD1_CNT(INIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Card-level model state
  int          m_state;
  logic [15:0] m_rca;
  int          m_cmd1;
  bit          m_crc, m_ill;

  logic [135:0] last_resp;
  int           last_len;
  logic [5:0]   tran_cmds [6] = '{6'd6, 6'd8, 6'd17, 6'd24, 6'd7, 6'd0};

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [119:0] msg);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = 126; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg,
                                           input int bad);
    logic [39:0] body;
    logic [6:0]  crc;
    body = {2'b01, idx, arg};
    if (bad == 2) body[38] = 1'b0;
    crc = ref_crc7({80'b0, body});
    if (bad == 1) crc = crc ^ (7'd1 << $urandom_range(0, 6));
    return {body, crc, (bad == 3) ? 1'b0 : 1'b1};
  endfunction

  task automatic model_reset();
    m_state = 0; m_rca = '0; m_cmd1 = 0; m_crc = 0; m_ill = 0;
  endtask

  task automatic model_frame(input logic [47:0] f, output bit ok, output int len,
                             output logic [135:0] resp);
    logic [5:0]  idx;
    logic [31:0] arg, st;
    logic [39:0] body;
    bit          match, rdy;
    idx  = f[45:40];
    arg  = f[39:8];
    len  = 0;
    resp = '0;
    ok   = !f[47] && f[46] && f[0] && (ref_crc7({80'b0, f[47:8]}) == f[7:1]);
    if (!ok) begin
      m_crc = 1;
      return;
    end
    match = (arg[31:16] == m_rca);
    st    = 32'h100 | (32'(m_state) << 9) | (m_crc ? 32'h0080_0000 : 32'h0)
          | (m_ill ? 32'h0040_0000 : 32'h0);
    body  = {2'b00, idx, st};
    if (idx == 0) begin
      m_state = 0; m_rca = '0; m_cmd1 = 0;
    end else if (idx == 1 && m_state == 0) begin
      rdy  = (m_cmd1 >= INIT);
      resp = {2'b00, 6'h3F, rdy, OCR[30:0], 8'hFF, 88'b0};
      len  = 48;
      if (rdy) m_state = 1;
      else     m_cmd1++;
    end else if (idx == 2 && m_state == 1) begin
      resp = {2'b00, 6'h3F, CID, ref_crc7(CID), 1'b1};
      len  = 136;
      m_state = 2;
    end else if (idx == 3 && m_state == 2) begin
      len = 48;
      m_rca = arg[31:16];
      m_state = 3;
    end else if (idx == 9 && m_state == 3 && match) begin
      resp = {2'b00, 6'h3F, CSD, ref_crc7(CSD), 1'b1};
      len  = 136;
    end else if (idx == 7 && m_state == 3 && match) begin
      len = 48;
      m_state = 4;
    end else if (idx == 7 && m_state == 4 && !match) begin
      m_state = 3;
    end else if ((idx inside {6'd6, 6'd8, 6'd17, 6'd24}) && m_state == 4) begin
      len = 48;
    end else begin
      m_ill = 1;
    end
    if (len == 48 && idx != 1) begin
      resp  = {body, ref_crc7({80'b0, body}), 1'b1, 88'b0};
      m_crc = 0;
      m_ill = 0;
    end
  endtask

  task automatic send_bits(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      bus.emmc_cmd_i = f[i];
      @(posedge clk); #1;
    end
    bus.emmc_cmd_i = 1'b1;
  endtask

  task automatic run_frame(input logic [47:0] f, input int quiet);
    bit           ok;
    int           exp_len, lat, len, bad_idle, limit;
    logic [135:0] exp_resp, got;
    last_resp = '0;
    last_len  = 0;
    send_bits(f);
    model_frame(f, ok, exp_len, exp_resp);
    check("cmd_valid", bus.cmd_valid_o, ok);
    check("crc_err", bus.crc_err_o, !ok);
    if (ok) begin
      check("cmd_idx", bus.cmd_idx_o, f[45:40]);
      check("cmd_arg", bus.cmd_arg_o, f[39:8]);
    end
    lat = 0;
    bad_idle = 0;
    limit = (exp_len != 0) ? NCR + 8 : quiet;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("pulse_width", {bus.cmd_valid_o, bus.crc_err_o}, 2'b00);
      if (bus.emmc_cmd_oe_o) begin
        lat = k;
        break;
      end
      if (!bus.emmc_cmd_o) bad_idle++;
    end
    check("idle_high", bad_idle, 0);
    if (exp_len == 0) begin
      check("no_resp", lat, 0);
    end else begin
      check("ncr_latency", lat, NCR);
      len = 0;
      got = '0;
      while (bus.emmc_cmd_oe_o && len < 200) begin
        got = {got[134:0], bus.emmc_cmd_o};
        len++;
        @(posedge clk); #1;
      end
      if (len <= 136) got = got << (136 - len);
      check("resp_len", len, exp_len);
      check("resp_bits", got, exp_resp);
      check("cmd_after_oe", bus.emmc_cmd_o, 1'b1);
      last_resp = got;
      last_len  = len;
    end
    check("card_state", bus.card_state_o, m_state);
    check("rca", bus.rca_o, m_rca);
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int bad,
                        input int quiet);
    run_frame(mk_frame(idx, arg, bad), quiet);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_oe"}, bus.emmc_cmd_oe_o, 1'b0);
    check({tag, "_cmd_o"}, bus.emmc_cmd_o, 1'b1);
    check({tag, "_valid"}, bus.cmd_valid_o, 1'b0);
    check({tag, "_crcerr"}, bus.crc_err_o, 1'b0);
    check({tag, "_idx"}, bus.cmd_idx_o, 6'd0);
    check({tag, "_arg"}, bus.cmd_arg_o, 32'd0);
    check({tag, "_state"}, bus.card_state_o, 4'd0);
    check({tag, "_rca"}, bus.rca_o, 16'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r, lat;
    logic [5:0]  idx;
    logic [31:0] arg;
    int          bad;

    bus.emmc_cmd_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_reset_values("reset");

    run_frame(48'h40_0000_0000_95, 200);
    check("cmd0_state", bus.card_state_o, 4'd0);

    do_cmd(6'd1, 32'h40FF8080, 0, 64);
    check("r3_ocr_1", last_resp[127:96], 32'h00FF8080);
    do_cmd(6'd1, 32'h40FF8080, 0, 64);
    check("r3_ocr_2", last_resp[127:96], 32'h00FF8080);
    do_cmd(6'd1, 32'h40FF8080, 0, 64);
    check("r3_ocr_3", last_resp[127:96], 32'h80FF8080);
    check("state_ready", bus.card_state_o, 4'd1);

    do_cmd(6'd2, 32'h0, 0, 64);
    check("r2_cid", last_resp[127:8], CID);
    check("r2_len", last_len, 136);
    do_cmd(6'd3, 32'h00040000, 0, 64);
    check("r1_cmd3", last_resp[127:96], 32'h00000500);
    check("rca_cmd3", bus.rca_o, 16'h0004);
    check("state_stby", bus.card_state_o, 4'd3);

    do_cmd(6'd7, 32'h00040000, 1, 64);
    check("state_after_bad", bus.card_state_o, 4'd3);
    do_cmd(6'd7, 32'h00040000, 0, 64);
    check("r1_cmd7", last_resp[127:96], 32'h00800700);
    check("state_tran", bus.card_state_o, 4'd4);

    do_cmd(6'd2, 32'h0, 0, 64);
    do_cmd(6'd17, 32'h0, 0, 64);
    check("r1_cmd17", last_resp[127:96], 32'h00400900);

    // Back to stby, then reset in the middle of a CMD9 R2
    do_cmd(6'd7, 32'h0, 0, 64);
    send_bits(mk_frame(6'd9, 32'h00040000, 0));
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.emmc_cmd_oe_o) begin
        lat = k;
        break;
      end
    end
    check("r2_csd_start", lat, NCR);
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("r2_mid_oe", bus.emmc_cmd_oe_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midreset");
    rst = 1'b0;
    model_reset();

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        case (m_state)
          0: idx = 6'd1;
          1: idx = 6'd2;
          2: idx = 6'd3;
          3: idx = (r % 2 == 0) ? 6'd7 : 6'd9;
          default: idx = tran_cmds[$urandom_range(0, 5)];
        endcase
      end else begin
        idx = 6'($urandom_range(0, 63));
      end
      arg = $urandom;
      if ($urandom_range(0, 3) != 0) arg[31:16] = m_rca;
      bad = $urandom_range(0, 11);
      bad = (bad < 3) ? bad + 1 : 0;
      do_cmd(idx, arg, bad, 64);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
